par_to_serial_tx: RTL and testbench
===================================

// Module: par_to_serial_tx
// PURPOSE
//   Transmit end of the PHY serial link: converts 8b parallel words into a 1b serial stream at 32f.
//   Sends MSB first. Inserts idle symbol 8'hBC whenever no data is offered.
//   Sends a start-up train of BC symbols so the far-end receiver can declare itself active.
//   Upstream hands over one byte per 8-bit symbol slot through a valid/ready handshake.
// PARAMETERS
//   N_BC_INIT   8      number of BC symbols sent after reset before data is accepted (>=5)
//   IDLE_SYM    8'hBC  idle/comma symbol
// PORTS
//   clk_32f    in   1  bit clock; sole clock; all flops on posedge
//   reset_L    in   1  asynchronous, active-low reset
//   data_in    in   8  parallel byte from upstream
//   valid_in   in   1  data_in holds a byte to send
//   ready_out  out  1  byte accepted on this edge when valid_in=1
//   data_out   out  1  serial output bit (registered)
//   active     out  1  start-up train done; data path open
//   bc_err     out  1  1-cycle pulse: data byte equal to IDLE_SYM accepted (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, reset_L=0): shift_reg=0, bit_cnt=0, state=INIT, bc_cnt=0.
//     Outputs: data_out=0, active=0, ready_out=0, bc_err=0. Reset mid-symbol aborts that symbol.
//   bit_cnt: 3b free-running counter 0..7, wraps 7->0. Symbol slot = 8 clk_32f cycles.
//   data_out = shift_reg[7].
//   bit_cnt!=7: shift_reg <= {shift_reg[6:0],1'b0}.
//   bit_cnt==7 (load edge): shift_reg <= next symbol, so its MSB appears on data_out next cycle.
//   First symbol after reset is 8'h00 (reset content); it is followed by the BC train.
//   FSM, 2 states:
//     INIT: each load edge loads IDLE_SYM and increments bc_cnt.
//       On the load of the N_BC_INIT-th BC: state->ACTIVE, active<=1.
//       ready_out=0 throughout INIT.
//     ACTIVE: ready_out = (bit_cnt==7), combinational.
//       Load edge with valid_in=1: load data_in (handshake completes).
//       Load edge with valid_in=0: load IDLE_SYM.
//       ACTIVE is left only by reset.
//   Handshake: upstream holds data_in/valid_in stable until ready_out&valid_in.
//     valid_in may stay high across back-to-back slots: one byte per slot, no gaps.
//   Throughput: max 1 byte per 8 cycles.
//     Latency: accepted byte's MSB on data_out 1 cycle after the load edge; LSB 8 cycles after.
//   active is registered; once set it stays 1 until reset.
// CONFIGURATION
//   Macro TX_BC_GUARD_EN.
//   Defined: in ACTIVE, an accepted data_in==IDLE_SYM is consumed.
//     Its symbol is still sent (indistinguishable from idle at the receiver).
//     bc_err pulses high for the cycle after the load edge. Nothing else changes.
//   Undefined: no check; bc_err is tied to 0.
// STRUCTURE
//   Shared package phy_pkg:
//     IDLE_SYM constant.
//     TX state encoding (INIT=1'b0, ACTIVE=1'b1).
//     SYM_W=8, BIT_CNT_W=3.
//   Single flat module; no sub-module (counter + shift reg + 2-state FSM).
// TESTING
//   1 Reset then run 16 slots, valid_in=0:
//     -> slot0 8'h00, slots1-8 8'hBC, active=1 from load of slot 8, later slots 8'hBC.
//   2 After active, valid_in=1 data_in=8'hA5 for one slot:
//     -> ready_out pulses once at bit_cnt==7; serial 1,0,1,0,0,1,0,1, then BC.
//   3 Back-to-back 8'h01,8'h02,8'h03 with valid_in held high:
//     -> three consecutive slots, no BC between, ready_out every 8th cycle.
//   4 valid_in=1 during INIT -> ready_out=0, byte not sent until first ACTIVE load edge.
//   5 reset_L low mid-symbol (bit_cnt=4) while sending 8'hF0:
//     -> data_out=0 and active=0 immediately; BC train restarts after release.
//   6 TX_BC_GUARD_EN defined, accept 8'hBC in ACTIVE -> bc_err=1 for one cycle.
//     Undefined -> bc_err stays 0.
//   Loopback: feed data_out into the team serial-to-parallel receiver.
//     Check decoded bytes equal sent bytes and receiver active rises.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY link definitions: symbol geometry, idle/comma symbol and TX FSM encoding.
package phy_pkg;
  localparam int SYM_W     = 8;
  localparam int BIT_CNT_W = 3;

  localparam logic [SYM_W-1:0] IDLE_SYM = 8'hBC;

  typedef enum logic {
    TX_INIT   = 1'b0,
    TX_ACTIVE = 1'b1
  } tx_state_t;
endpackage

// File: rtl/par_to_serial_tx.sv
// Parallel-to-serial PHY transmitter: 8b symbols out MSB first at 32f, BC start-up train, idle fill.
// Optional macro TX_BC_GUARD_EN flags accepted data bytes that collide with the idle symbol.
module par_to_serial_tx #(
  parameter int                          N_BC_INIT = 8,
  parameter logic [phy_pkg::SYM_W-1:0]   IDLE_SYM  = phy_pkg::IDLE_SYM
) (
  input  logic                        clk_32f,
  input  logic                        reset_L,
  input  logic [phy_pkg::SYM_W-1:0]   data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  output logic                        data_out,
  output logic                        active,
  output logic                        bc_err
);
  import phy_pkg::*;

  localparam int BC_CNT_W = $clog2(N_BC_INIT + 1);

  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [SYM_W-1:0]     shift_reg;
  logic [SYM_W-1:0]     next_sym;
  logic [BC_CNT_W-1:0]  bc_cnt;
  tx_state_t            state, state_nxt;
  logic                 load;
  logic                 last_bc;

  assign load     = (bit_cnt == BIT_CNT_W'(SYM_W - 1));
  assign last_bc  = (bc_cnt == BC_CNT_W'(N_BC_INIT - 1));
  assign data_out = shift_reg[SYM_W-1];

  // FSM state register
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) state <= TX_INIT;
    else          state <= state_nxt;
  end

  // next state, handshake and symbol selection
  always_comb begin
    state_nxt = state;
    next_sym  = IDLE_SYM;
    ready_out = 1'b0;
    case (state)
      TX_INIT: begin
        if (load && last_bc) state_nxt = TX_ACTIVE;
      end
      TX_ACTIVE: begin
        ready_out = load;
        if (load && valid_in) next_sym = data_in;
      end
      default: state_nxt = TX_INIT;
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      bc_cnt    <= '0;
      active    <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
      shift_reg <= load ? next_sym : {shift_reg[SYM_W-2:0], 1'b0};
      if (load && state == TX_INIT) bc_cnt <= bc_cnt + BC_CNT_W'(1);
      // sticky until reset; rises on the edge that loads the last train symbol
      if (state_nxt == TX_ACTIVE) active <= 1'b1;
    end
  end

`ifdef TX_BC_GUARD_EN
  logic bc_hit;
  assign bc_hit = (state == TX_ACTIVE) && load && valid_in && (data_in == IDLE_SYM);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) bc_err <= 1'b0;
    else          bc_err <= bc_hit;
  end
`else
  assign bc_err = 1'b0;
`endif

endmodule

// File: tb/tb_par_to_serial_tx.sv
// Bench for par_to_serial_tx: slot-level reference model (symbol per 8-cycle slot) with directed and random traffic.
module tb_par_to_serial_tx;
  import phy_pkg::*;

  localparam int         NBC = 8;
  localparam logic [7:0] BC  = 8'hBC;
`ifdef TX_BC_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic       clk_32f  = 1'b0;
  logic       reset_L  = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out, data_out, active, bc_err;

  int         errors = 0;
  int         checks = 0;

  // reference model: cycle count since reset release, symbol of current and next slot
  int         t;
  logic [7:0] cur_sym, nxt_sym, rx_byte;
  bit         cur_is_data, nxt_is_data, acc, gaps;
  logic [7:0] tx_q[$];

  par_to_serial_tx #(.N_BC_INIT(NBC), .IDLE_SYM(BC)) dut (
    .clk_32f  (clk_32f),
    .reset_L  (reset_L),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .data_out (data_out),
    .active   (active),
    .bc_err   (bc_err)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // upstream: once valid is raised it is held until accepted
  task automatic drive();
    if (!valid_in || acc) begin
      if (tx_q.size() > 0 && (!gaps || $urandom_range(0, 3) == 0)) begin
        valid_in = 1'b1;
        data_in  = tx_q[0];
      end else begin
        valid_in = 1'b0;
        data_in  = 8'($urandom);
      end
    end
    acc = 1'b0;
  endtask

  task automatic step();
    int pos, slot;
    bit er;
    @(negedge clk_32f);
    pos  = t % 8;
    slot = t / 8;
    er   = (pos == 7) && (slot >= NBC);
    chk("data_out", 8'(data_out), 8'(cur_sym[7-pos]));
    chk("ready_out", 8'(ready_out), 8'(er));
    chk("active", 8'(active), 8'(slot >= NBC));
    chk("bc_err", 8'(bc_err), 8'(GUARD && pos == 0 && cur_is_data && cur_sym == BC));
    rx_byte = {rx_byte[6:0], data_out};
    if (pos == 7) chk("slot_byte", rx_byte, cur_sym);
    if (er && valid_in) begin
      nxt_sym     = data_in;
      nxt_is_data = 1'b1;
      acc         = 1'b1;
      void'(tx_q.pop_front());
    end
    @(posedge clk_32f);
    #1;
    t++;
    if (t % 8 == 0) begin
      cur_sym     = nxt_sym;
      cur_is_data = nxt_is_data;
      nxt_sym     = BC;
      nxt_is_data = 1'b0;
    end
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset_L  = 1'b0;
    valid_in = 1'b0;
    tx_q.delete();
    #1;
    chk("rst_data_out", 8'(data_out), 8'h00);
    chk("rst_active", 8'(active), 8'h00);
    chk("rst_ready", 8'(ready_out), 8'h00);
    chk("rst_bc_err", 8'(bc_err), 8'h00);
    @(posedge clk_32f);
    @(posedge clk_32f);
    #1;
    reset_L     = 1'b1;
    t           = 0;
    cur_sym     = 8'h00;
    cur_is_data = 1'b0;
    nxt_sym     = BC;
    nxt_is_data = 1'b0;
    acc         = 1'b0;
    rx_byte     = 8'h00;
  endtask

  task automatic wait_data(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (cur_is_data) found = 1'b1;
      else step();
    end
    if (cur_is_data) found = 1'b1;
  endtask

  initial begin
    bit found;
    int k;
    gaps = 1'b0;
    #2;

    // 1: start-up train with nothing offered
    do_reset();
    run(16 * 8);

    // 2: single byte A5
    tx_q.push_back(8'hA5);
    drive();
    run(3 * 8);

    // 3: back-to-back bytes with valid held high
    tx_q.push_back(8'h01);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    drive();
    run(6 * 8);

    // 4: valid raised during INIT is held until the first ACTIVE load edge
    do_reset();
    tx_q.push_back(8'h5A);
    drive();
    wait_data(300, found);
    chk("init_hold_found", 8'(found), 8'h01);
    chk("init_hold_slot", 8'(t / 8), 8'(NBC + 1));
    run(2 * 8);

    // 6: idle-valued data byte accepted in ACTIVE
    tx_q.push_back(BC);
    drive();
    run(3 * 8);

    // 5: reset mid-symbol while F0 is on the wire
    tx_q.push_back(8'hF0);
    drive();
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cur_is_data && cur_sym == 8'hF0 && t % 8 == 4) found = 1'b1;
      else step();
    end
    chk("f0_reached", 8'(found), 8'h01);
    do_reset();
    run(12 * 8);

    // random traffic with gaps, idle-valued bytes mixed in
    gaps = 1'b1;
    for (int i = 0; i < 30; i++) tx_q.push_back((i % 5 == 0) ? BC : 8'($urandom));
    drive();
    k = 0;
    while (tx_q.size() > 0 && k < 3000) begin
      step();
      k++;
    end
    chk("rand_drain", 8'(tx_q.size()), 8'h00);
    run(3 * 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
